// File: rtl/alu_mc_pkg.sv
// Shared opcode fields, full 7-bit ALU_OP codes ({FUN, OP[3:2], OP[1:0]}) and FSM state type for alu_mc.
package alu_mc_pkg;

    localparam logic [2:0] ALU_CAL     = 3'd0;
    localparam logic [2:0] ALU_IMM     = 3'd1;
    localparam logic [2:0] BRANCH      = 3'd2;
    localparam logic [2:0] BRANCH_JUMP = 3'd3;

    localparam logic [1:0] NUM_CAL       = 2'd0;
    localparam logic [1:0] BIN_CAL       = 2'd1;
    localparam logic [1:0] BIM_SHIFT     = 2'd2;
    localparam logic [1:0] BIN_SHIFT_IMM = 2'd3;

    // Immediate, branch and jump ops all live in the OP[3:2] = 00 group.
    localparam logic [6:0] OP_ADD  = {ALU_CAL, NUM_CAL, 2'd0};
    localparam logic [6:0] OP_SUB  = {ALU_CAL, NUM_CAL, 2'd1};
    localparam logic [6:0] OP_MUL  = {ALU_CAL, NUM_CAL, 2'd2};
    localparam logic [6:0] OP_AND  = {ALU_CAL, BIN_CAL, 2'd0};
    localparam logic [6:0] OP_OR   = {ALU_CAL, BIN_CAL, 2'd1};
    localparam logic [6:0] OP_XOR  = {ALU_CAL, BIN_CAL, 2'd2};
    localparam logic [6:0] OP_SLL  = {ALU_CAL, BIM_SHIFT, 2'd0};
    localparam logic [6:0] OP_SRL  = {ALU_CAL, BIM_SHIFT, 2'd1};
    localparam logic [6:0] OP_SLLI = {ALU_CAL, BIN_SHIFT_IMM, 2'd0};
    localparam logic [6:0] OP_SRLI = {ALU_CAL, BIN_SHIFT_IMM, 2'd1};
    localparam logic [6:0] OP_ANDI = {ALU_IMM, NUM_CAL, 2'd0};
    localparam logic [6:0] OP_ORI  = {ALU_IMM, NUM_CAL, 2'd1};
    localparam logic [6:0] OP_XORI = {ALU_IMM, NUM_CAL, 2'd2};
    localparam logic [6:0] OP_ADDI = {ALU_IMM, NUM_CAL, 2'd3};
    localparam logic [6:0] OP_BEQ  = {BRANCH, NUM_CAL, 2'd0};
    localparam logic [6:0] OP_BNE  = {BRANCH, NUM_CAL, 2'd1};
    localparam logic [6:0] OP_BLT  = {BRANCH, NUM_CAL, 2'd2};
    localparam logic [6:0] OP_JAL  = {BRANCH_JUMP, NUM_CAL, 2'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_mul_seq.sv
// Iterative shift-add multiplier; done pulses combinationally during the final iteration
// and product carries that iteration's accumulator sum so the caller can register it on the same edge.
module alu_mul_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              active_q, active_d;
    logic [DATA_W-1:0] acc_sum;

    always_comb begin
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = active_q && (count_q == CNT_W'(1));
        product  = acc_sum;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        active_d = active_q;
        if (start) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            count_d  = CNT_W'(DATA_W);
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CNT_W'(1);
            active_d = !done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshake; MUL is delegated to alu_mul_seq,
// everything else resolves in one cycle. Outputs only update when a new result is captured.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        ALU_OP,
    input  logic [DATA_W-1:0] r0_data,
    input  logic [DATA_W-1:0] r1_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              B_PCSrc,
    output logic              zero,
    output logic              busy
);

    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;
    logic              pc_q, pc_d;
    logic              zero_q, zero_d;

    logic              accept;
    logic              is_mul;
    logic              mul_start;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;
    logic [DATA_W-1:0] alu_res;
    logic              alu_pc;
    logic              shamt_ok;
    logic [DATA_W-1:0] shl_res;
    logic [DATA_W-1:0] shr_res;

    alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .mcand_i  (r0_data),
        .mplier_i (r1_data),
        .done     (mul_done),
        .product  (mul_product)
    );

    // Whole r1_data is compared so large amounts saturate to zero instead of wrapping.
    always_comb begin
        shamt_ok = r1_data < SHIFT_LIMIT;
        shl_res  = shamt_ok ? (r0_data << r1_data[SHAMT_W-1:0]) : '0;
        shr_res  = shamt_ok ? (r0_data >> r1_data[SHAMT_W-1:0]) : '0;
        alu_res  = '0;
        alu_pc   = 1'b0;
        is_mul   = 1'b0;
        case (ALU_OP)
            OP_ADD, OP_ADDI: alu_res = r0_data + r1_data;
            OP_SUB:          alu_res = r0_data - r1_data;
            OP_MUL:          is_mul  = 1'b1;
            OP_AND, OP_ANDI: alu_res = r0_data & r1_data;
            OP_OR,  OP_ORI:  alu_res = r0_data | r1_data;
            OP_XOR, OP_XORI: alu_res = r0_data ^ r1_data;
            OP_SLL, OP_SLLI: alu_res = shl_res;
            OP_SRL, OP_SRLI: alu_res = shr_res;
            OP_BEQ:          alu_pc  = (r0_data == r1_data);
            OP_BNE:          alu_pc  = (r0_data != r1_data);
            OP_BLT:          alu_pc  = (r0_data < r1_data);
            OP_JAL:          alu_pc  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == ST_IDLE) || ((state_q == ST_RESULT) && out_ready);
        accept      = in_valid && in_ready;
        mul_start   = accept && is_mul;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        o_data_d    = o_data_q;
        pc_d        = pc_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (accept && is_mul) begin
                    state_d     = ST_MUL;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    state_d     = ST_RESULT;
                    out_valid_d = 1'b1;
                    o_data_d    = alu_res;
                    pc_d        = alu_pc;
                    zero_d      = (alu_res == '0);
                end else if ((state_q == ST_RESULT) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d     = ST_RESULT;
                    out_valid_d = 1'b1;
                    o_data_d    = mul_product;
                    pc_d        = 1'b0;
                    zero_d      = (mul_product == '0);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            o_data_q    <= '0;
            pc_q        <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            o_data_q    <= o_data_d;
            pc_q        <= pc_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o_data    = o_data_q;
    assign B_PCSrc   = pc_q;
    assign zero      = zero_q;
    assign busy      = (state_q == ST_MUL);

endmodule
